// File: rtl/ascii_to_time_pkg.sv
// Shared constants and FSM state encoding for the HH:MM:SS<CR> command parser.
package ascii_to_time_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_COLON = 8'h3a;
  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_ESC   = 8'h1b;

  // Each state names the field expected next; H1 is never entered because
  // IDLE itself accepts the hour tens digit.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_H1   = 4'd1,
    ST_H0   = 4'd2,
    ST_C1   = 4'd3,
    ST_M1   = 4'd4,
    ST_M0   = 4'd5,
    ST_C2   = 4'd6,
    ST_S1   = 4'd7,
    ST_S0   = 4'd8,
    ST_END  = 4'd9
  } state_t;

endpackage

// File: rtl/ascii_to_time_if.sv
// Byte-in / time-out bundle between the UART RX, the parser and the time-load logic.
interface ascii_to_time_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic [3:0]            hour1;
  logic [3:0]            hour0;
  logic [3:0]            min1;
  logic [3:0]            min0;
  logic [3:0]            sec1;
  logic [3:0]            sec0;
  logic                  time_valid;
  logic                  parse_error;
  logic                  busy;

  modport master (
    output rx_data, rx_done,
    input  hour1, hour0, min1, min0, sec1, sec0, time_valid, parse_error, busy
  );

  modport slave (
    input  rx_data, rx_done,
    output hour1, hour0, min1, min0, sec1, sec0, time_valid, parse_error, busy
  );

endinterface

// File: rtl/ascii_to_time_digit.sv
// ascii_to_digit: classifies a byte as a decimal digit and returns its 4-bit value.
module ascii_to_digit
  import ascii_to_time_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_digit,
  output logic [3:0] o_value
);

  // Decode '0'..'9'; 0x30 has a zero low nibble, so byte - 0x30 is just the low nibble.
  always_comb begin
    o_is_digit = 1'b0;
    o_value    = 4'd0;
    if ((i_byte >= ASCII_0) && (i_byte <= ASCII_9)) begin
      o_is_digit = 1'b1;
      o_value    = i_byte[3:0];
    end else begin
      o_is_digit = 1'b0;
      o_value    = 4'd0;
    end
  end

endmodule

// File: rtl/ascii_to_time.sv
// Parses HH:MM:SS<CR> from UART RX bytes into six committed BCD digits.
// Optional digit range checking is enabled with ASCII_TO_TIME_RANGE_CHECK_EN.
module ascii_to_time
  import ascii_to_time_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  ascii_to_time_if.slave bus
);

  logic [DATA_WIDTH-1:0] w_rx_byte;
  logic                  w_is_digit;
  logic [3:0]            w_value;
  logic                  w_range_ok;
  logic                  w_digit_ok;
  logic                  w_match;
  logic                  w_ignorable;

  state_t          r_state;
  logic [5:0][3:0] r_shadow;
  logic [5:0][3:0] r_digits;
  logic            r_time_valid;
  logic            r_parse_error;
  logic            r_busy;

  assign w_rx_byte = bus.rx_data;

  ascii_to_digit u_digit (
    .i_byte     (w_rx_byte[7:0]),
    .o_is_digit (w_is_digit),
    .o_value    (w_value)
  );

`ifdef ASCII_TO_TIME_RANGE_CHECK_EN
  // Reject digits that cannot form a valid 24-hour time.
  always_comb begin
    w_range_ok = 1'b1;
    case (r_state)
      ST_IDLE: w_range_ok = (w_value <= 4'd2);
      ST_H0: begin
        if (r_shadow[5] == 4'd2) begin
          w_range_ok = (w_value <= 4'd3);
        end else begin
          w_range_ok = 1'b1;
        end
      end
      ST_M1, ST_S1: w_range_ok = (w_value <= 4'd5);
      default: w_range_ok = 1'b1;
    endcase
  end
`else
  assign w_range_ok = 1'b1;
`endif

  assign w_digit_ok  = w_is_digit & w_range_ok;
  assign w_ignorable = (w_rx_byte == ASCII_SP) || (w_rx_byte == ASCII_CR) ||
                       (w_rx_byte == ASCII_LF);

  // Does the byte fit the field expected in the current (non-idle) state?
  always_comb begin
    w_match = 1'b0;
    case (r_state)
      ST_H0, ST_M1, ST_M0, ST_S1, ST_S0: w_match = w_digit_ok;
      ST_C1, ST_C2:                      w_match = (w_rx_byte == ASCII_COLON);
      ST_END:                            w_match = (w_rx_byte == ASCII_CR);
      default:                           w_match = 1'b0;
    endcase
  end

  // Command FSM with shadow capture, commit and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shadow      <= '0;
      r_digits      <= '0;
      r_time_valid  <= 1'b0;
      r_parse_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_time_valid  <= 1'b0;
      r_parse_error <= 1'b0;
      if (bus.rx_done) begin
        if (w_rx_byte == ASCII_ESC) begin
          r_state  <= ST_IDLE;
          r_shadow <= '0;
          r_busy   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
          if (w_digit_ok) begin
            r_shadow[5] <= w_value;
            r_state     <= ST_H0;
            r_busy      <= 1'b1;
          end else if (w_ignorable) begin
            r_state <= ST_IDLE;
          end else begin
            r_parse_error <= 1'b1;
          end
        end else if (w_match) begin
          case (r_state)
            ST_H0: begin
              r_shadow[4] <= w_value;
              r_state     <= ST_C1;
            end
            ST_C1: r_state <= ST_M1;
            ST_M1: begin
              r_shadow[3] <= w_value;
              r_state     <= ST_M0;
            end
            ST_M0: begin
              r_shadow[2] <= w_value;
              r_state     <= ST_C2;
            end
            ST_C2: r_state <= ST_S1;
            ST_S1: begin
              r_shadow[1] <= w_value;
              r_state     <= ST_S0;
            end
            ST_S0: begin
              r_shadow[0] <= w_value;
              r_state     <= ST_END;
            end
            ST_END: begin
              r_digits     <= r_shadow;
              r_time_valid <= 1'b1;
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
            end
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end else begin
          // The offending byte is consumed; parsing restarts on the next byte.
          r_parse_error <= 1'b1;
          r_shadow      <= '0;
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign bus.hour1       = r_digits[5];
  assign bus.hour0       = r_digits[4];
  assign bus.min1        = r_digits[3];
  assign bus.min0        = r_digits[2];
  assign bus.sec1        = r_digits[1];
  assign bus.sec0        = r_digits[0];
  assign bus.time_valid  = r_time_valid;
  assign bus.parse_error = r_parse_error;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_ascii_to_time.sv
// Directed plus randomized bench for ascii_to_time against a template-matching reference model.
module tb_ascii_to_time;

  logic clk = 1'b0;
  logic rst;

  ascii_to_time_if #(.DATA_WIDTH(8)) bus ();

  ascii_to_time #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes of the command accepted so far, plus committed digits.
  logic [7:0]  m_buf[$];
  logic [23:0] m_digits = 24'd0;
  logic        m_tv = 1'b0;
  logic        m_pe = 1'b0;

  function automatic logic is_dig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic [3:0] dval(input logic [7:0] b);
    logic [7:0] t;
    t = b - 8'h30;
    return t[3:0];
  endfunction

  // Template "DD:DD:DD<CR>": position p of the partial command decides what is legal.
  task automatic model_byte(input logic [7:0] b);
    int   p;
    logic ok;
    m_tv = 1'b0;
    m_pe = 1'b0;
    p    = m_buf.size();
    if (b == 8'h1b) begin
      m_buf.delete();
    end else if (p == 0 && (b == 8'h20 || b == 8'h0d || b == 8'h0a)) begin
      m_tv = 1'b0;
    end else begin
      if (p == 2 || p == 5) ok = (b == 8'h3a);
      else if (p == 8)      ok = (b == 8'h0d);
      else                  ok = is_dig(b);
`ifdef ASCII_TO_TIME_RANGE_CHECK_EN
      if (p == 0) ok = ok && (b <= 8'h32);
      if (p == 1 && m_buf[0] == 8'h32) ok = ok && (b <= 8'h33);
      if (p == 3 || p == 6) ok = ok && (b <= 8'h35);
`endif
      if (!ok) begin
        m_pe = 1'b1;
        m_buf.delete();
      end else if (p == 8) begin
        m_digits = {dval(m_buf[0]), dval(m_buf[1]), dval(m_buf[3]),
                    dval(m_buf[4]), dval(m_buf[6]), dval(m_buf[7])};
        m_tv = 1'b1;
        m_buf.delete();
      end else begin
        m_buf.push_back(b);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_dig(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_bit({tag, " time_valid"}, bus.time_valid, m_tv);
    check_bit({tag, " parse_error"}, bus.parse_error, m_pe);
    check_bit({tag, " busy"}, bus.busy, m_buf.size() != 0);
    check_dig({tag, " digits"}, {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0},
              m_digits);
  endtask

  // Called at a negedge; rx_done stays high so consecutive calls are back-to-back.
  task automatic send_byte(input string tag, input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    model_byte(b);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    bus.rx_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      m_tv = 1'b0;
      m_pe = 1'b0;
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  task automatic send_str(input string tag, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(tag, s[i]);
      if (gap > 0) idle(tag, gap);
    end
  endtask

  task automatic do_reset(input string tag);
    rst         = 1'b1;
    bus.rx_done = 1'b0;
    m_buf.delete();
    m_digits = 24'd0;
    m_tv     = 1'b0;
    m_pe     = 1'b0;
    @(negedge clk);
    check_outputs(tag);
    rst = 1'b0;
    idle(tag, 1);
  endtask

  initial begin
    logic [7:0] b;
    int         p;
    rst         = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    idle("post_reset", 2);

    // Well-formed command with CR LF terminator, spaced bytes.
    send_str("cmd_crlf", "12:34:56", 1);
    send_byte("cmd_crlf", 8'h0d);
    send_byte("cmd_crlf", 8'h0a);
    idle("cmd_crlf", 2);

    // Bad separator; trailing bytes re-parsed from IDLE.
    send_str("bad_sep", "12-34:56", 0);
    send_byte("bad_sep", 8'h0d);
    idle("bad_sep", 1);

    // ESC abort mid-command, then a fresh command.
    send_str("esc_abort", "12:3", 0);
    send_byte("esc_abort", 8'h1b);
    send_str("esc_abort", "01:02:03", 0);
    send_byte("esc_abort", 8'h0d);
    idle("esc_abort", 1);

    // Hour 24: rejected with range checking, committed without it.
    send_str("hour24", "24:00:00", 0);
    send_byte("hour24", 8'h0d);
    idle("hour24", 1);

    // Two commands fully back-to-back.
    send_str("b2b", "23:59:59", 0);
    send_byte("b2b", 8'h0d);
    send_str("b2b", "00:00:01", 0);
    send_byte("b2b", 8'h0d);
    idle("b2b", 1);

    // Reset mid-command, then normal operation.
    send_str("mid_reset", "11:1", 0);
    do_reset("mid_reset");
    send_str("after_reset", "11:11:11", 0);
    send_byte("after_reset", 8'h0d);
    idle("after_reset", 1);

    // Randomized traffic biased toward well-formed commands.
    for (int n = 0; n < 600; n++) begin
      p = m_buf.size();
      if ($urandom_range(0, 9) < 6) begin
        if (p == 2 || p == 5)      b = 8'h3a;
        else if (p == 8)           b = 8'h0d;
        else if (p == 0)           b = 8'h30 + 8'($urandom_range(0, 2));
        else if (p == 3 || p == 6) b = 8'h30 + 8'($urandom_range(0, 5));
        else                       b = 8'h30 + 8'($urandom_range(0, 9));
      end else begin
        case ($urandom_range(0, 6))
          0:       b = 8'h1b;
          1:       b = 8'h0a;
          2:       b = 8'h20;
          3:       b = 8'h0d;
          4:       b = 8'h3a;
          5:       b = 8'h30 + 8'($urandom_range(0, 9));
          default: b = 8'($urandom_range(0, 255));
        endcase
      end
      send_byte("random", b);
      if ($urandom_range(0, 2) == 0) idle("random_gap", $urandom_range(1, 2));
    end
    idle("final", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascii_to_time.md
# ascii_to_time

Receive-side counterpart of the time-report serializer: consumes bytes from the UART receiver and parses a time-set command of the form `HH:MM:SS<CR>` into six BCD digits. A complete, well-formed command yields a one-cycle `time_valid` strobe with the new digits; malformed input yields `parse_error`. It sits between the UART RX and the clock/stopwatch time-load logic. Partially received commands never disturb the committed digit outputs.

## Interface
- `DATA_WIDTH`, 8: byte width of `rx_data`; only 8 is supported.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  DATA_WIDTH  received byte; valid only while `rx_done` is high.
- `rx_done`  in  1  one-cycle byte-valid strobe from the UART RX.
- `hour1`, `hour0`, `min1`, `min0`, `sec1`, `sec0`  out  4 each  committed BCD digits (tens, units).
- `time_valid`  out  1  one-cycle strobe; digits are updated in the same cycle.
- `parse_error`  out  1  one-cycle strobe on a rejected byte.
- `busy`  out  1  high while a command is partially received (state ≠ IDLE).

## Operation
- FSM states: IDLE, H1, H0, C1, M1, M0, C2, S1, S0, END. The state advances only on cycles with `rx_done`=1.
- IDLE:
  - Digit '0'–'9' (0x30–0x39): store in shadow `hour1`, go to H0.
  - Space (0x20), CR (0x0d), LF (0x0a): ignored; stay in IDLE.
  - Any other byte: `parse_error`.
- Expected sequence: digit → H0, digit → C1, ':' (0x3a) → M1, digit → M0, digit → C2, ':' → S1, digit → S0, digit → END, CR → commit.
- Each digit is stored as `rx_data - 0x30` into the matching shadow register.
- Commit on CR in END: the six shadow digits are copied to the outputs, `time_valid` pulses, and the FSM returns to IDLE.
- Mismatched byte in any non-IDLE state: `parse_error` pulses, the shadow registers are discarded, and the FSM goes to IDLE. The offending byte is consumed, not re-parsed.
- ESC (0x1b) in any state: silent abort to IDLE, no `parse_error`.
- LF after a commit arrives in IDLE and is ignored, so `CR LF` terminators are accepted.
- Outputs hold their last committed values indefinitely; there is no auto-clear.

## Timing
- All outputs are registered.
- Reset values: all digits 0, `time_valid`=0, `parse_error`=0, `busy`=0, state IDLE, shadow registers 0.
- Latency: `time_valid`, `parse_error` and the updated digits appear on the cycle after the `rx_done` cycle of the deciding byte.
- `busy` rises the cycle after the first accepted digit and falls the cycle after the commit, error or abort.
- Back-to-back `rx_done` on consecutive cycles is fully supported, including a new digit on the cycle `time_valid` is high.
- `rx_done`=0 cycles: no state change, no strobes.
- Reset mid-command: the partial command is lost and the committed digits return to 0.

## Configuration
- `ASCII_TO_TIME_RANGE_CHECK_EN` defined:
  - Digits are range-checked on arrival: hour1 ≤ 2; hour0 ≤ 3 when hour1 = 2; min1 ≤ 5; sec1 ≤ 5.
  - A violation is treated as a mismatched byte (`parse_error`, return to IDLE).
- Not defined: any decimal digit is accepted in every digit position, and out-of-range times are committed as received.

## Structure
- Shared package holds:
  - ASCII constants: `ASCII_0`=0x30, `ASCII_9`=0x39, `ASCII_COLON`=0x3a, `ASCII_CR`=0x0d, `ASCII_LF`=0x0a, `ASCII_SP`=0x20, `ASCII_ESC`=0x1b.
  - The FSM state encoding.
- One sub-module, `ascii_to_digit`, is the inverse of the digit-to-ASCII converter: outputs `is_digit` and the 4-bit value. Instantiate it once on `rx_data`.

## Test plan
- Send "12:34:56\r\n" → one `time_valid` pulse, outputs 1,2,3,4,5,6; no `parse_error`; `busy` low after the commit.
- Send "12-34:56\r" → `parse_error` on the '-' byte; remaining bytes are digits/colons in IDLE and some produce further errors; digits never change; no `time_valid`.
- Send "12:3" then ESC, then "01:02:03\r" → no error on ESC; final outputs 0,1,0,2,0,3.
- With `ASCII_TO_TIME_RANGE_CHECK_EN`, send "24:00:00\r" → `parse_error` on '4', digits unchanged; without the macro, 2,4,0,0,0,0 is committed.
- Send "23:59:59\r" with `rx_done` on consecutive cycles, followed immediately by "00:00:01\r" → two `time_valid` pulses, final outputs 0,0,0,0,0,1.
- Assert `rst` after "11:1" → all outputs 0 and `busy`=0; then "11:11:11\r" commits normally.
